// File: rtl/display_scan_decoder_if.sv
// Scanned seven-segment drive lines and the reconstructed frame outputs.
interface display_scan_decoder_if;
  logic [7:0]  an;
  logic [7:0]  dec_ddp;
  logic [31:0] digits;
  logic [7:0]  dps;
  logic [7:0]  blanks;
  logic        frame_valid;
  logic        frame_err;

  modport master (
    output an, dec_ddp,
    input  digits, dps, blanks, frame_valid, frame_err
  );

  modport slave (
    input  an, dec_ddp,
    output digits, dps, blanks, frame_valid, frame_err
  );
endinterface

// File: rtl/display_scan_decoder.sv
// Reconstructs 8 digits from a time-multiplexed seven-segment scan and
// publishes a full frame once every slot has been captured.
module display_scan_decoder #(
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic                   clock,
  input  logic                   reset,
  display_scan_decoder_if.slave  bus
);

  localparam int unsigned CNT_W   = (STABLE_CYCLES > 2) ? $clog2(STABLE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);

  typedef enum logic {ST_COLLECT, ST_PUBLISH} state_t;

  // Active-low a..g pattern -> {invalid, blank, nibble}
  function automatic logic [5:0] decode_seg(input logic [6:0] seg);
    logic [5:0] res;
    res = 6'b10_0000;
    case (seg)
      7'b0000001: res = 6'h00;
      7'b1001111: res = 6'h01;
      7'b0010010: res = 6'h02;
      7'b0000110: res = 6'h03;
      7'b1001100: res = 6'h04;
      7'b0100100: res = 6'h05;
      7'b0100000: res = 6'h06;
      7'b0001111: res = 6'h07;
      7'b0000000: res = 6'h08;
      7'b0000100: res = 6'h09;
      7'b0001000: res = 6'h0A;
      7'b1100000: res = 6'h0B;
      7'b0110001: res = 6'h0C;
      7'b1000010: res = 6'h0D;
      7'b0110000: res = 6'h0E;
      7'b0111000: res = 6'h0F;
      7'b1111111: res = 6'b01_0000;
      default:    res = 6'b10_0000;
    endcase
    return res;
  endfunction

  state_t           r_state, w_state_nxt;
  logic [7:0]       r_s_an, r_s_seg;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic             r_armed, w_armed_nxt;
  logic [7:0]       r_seen, w_seen_nxt;
  logic             r_err, w_err_acc, w_err_nxt;
  logic [31:0]      r_sh_dig, w_sh_dig;
  logic [7:0]       r_sh_dp, w_sh_dp;
  logic [7:0]       r_sh_blank, w_sh_blank;
  logic [31:0]      r_digits;
  logic [7:0]       r_dps, r_blanks;
  logic             r_frame_valid, r_frame_err;

  logic             w_change, w_capture, w_publish;
  logic [2:0]       w_slot;
  logic [5:0]       w_dec;

  // Stability filter, slot capture and frame sequencing
  always_comb begin
    w_state_nxt = r_state;
    w_change    = (bus.an != r_s_an) || (bus.dec_ddp != r_s_seg);
    w_cnt_nxt   = r_cnt;
    w_armed_nxt = r_armed;
    w_slot      = 3'd0;
    w_dec       = decode_seg(r_s_seg[7:1]);
    w_sh_dig    = r_sh_dig;
    w_sh_dp     = r_sh_dp;
    w_sh_blank  = r_sh_blank;
    w_seen_nxt  = r_seen;
    w_err_acc   = r_err;

    if (w_change)
      w_cnt_nxt = '0;
    else if (r_cnt != CNT_MAX)
      w_cnt_nxt = r_cnt + CNT_W'(1);

    for (int i = 0; i < 8; i++)
      if (!r_s_an[i]) w_slot = 3'(i);

    // Unchanged input means the live lines equal s, so this edge adds one more identical sample
    w_capture = r_armed && !w_change && (w_cnt_nxt == CNT_MAX) && $onehot(~r_s_an);

    if (w_change)
      w_armed_nxt = 1'b1;
    else if (w_capture)
      w_armed_nxt = 1'b0;

    if (w_capture) begin
      w_sh_dig[{w_slot, 2'b00} +: 4] = w_dec[3:0];
      w_sh_dp[w_slot]                = ~r_s_seg[0];
      w_sh_blank[w_slot]             = w_dec[4];
      w_seen_nxt                     = r_seen | (8'h01 << w_slot);
      w_err_acc                      = r_err | w_dec[5];
    end

    case (r_state)
      ST_COLLECT: if (w_capture && (w_seen_nxt == 8'hFF)) w_state_nxt = ST_PUBLISH;
      ST_PUBLISH: w_state_nxt = ST_COLLECT;
      default:    w_state_nxt = ST_COLLECT;
    endcase

    w_publish = (r_state == ST_COLLECT) && (w_state_nxt == ST_PUBLISH);
    w_err_nxt = w_err_acc;
    if (w_publish) begin
      w_seen_nxt = 8'h00;
      w_err_nxt  = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) r_state <= ST_COLLECT;
    else        r_state <= w_state_nxt;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_s_an        <= 8'hFF;
      r_s_seg       <= 8'hFF;
      r_cnt         <= '0;
      r_armed       <= 1'b1;
      r_seen        <= 8'h00;
      r_err         <= 1'b0;
      r_sh_dig      <= 32'h0;
      r_sh_dp       <= 8'h00;
      r_sh_blank    <= 8'h00;
      r_digits      <= 32'h0;
      r_dps         <= 8'h00;
      r_blanks      <= 8'h00;
      r_frame_valid <= 1'b0;
      r_frame_err   <= 1'b0;
    end else begin
      r_s_an        <= bus.an;
      r_s_seg       <= bus.dec_ddp;
      r_cnt         <= w_cnt_nxt;
      r_armed       <= w_armed_nxt;
      r_seen        <= w_seen_nxt;
      r_err         <= w_err_nxt;
      r_sh_dig      <= w_sh_dig;
      r_sh_dp       <= w_sh_dp;
      r_sh_blank    <= w_sh_blank;
      r_frame_valid <= w_publish;
      if (w_publish) begin
        r_digits    <= w_sh_dig;
        r_dps       <= w_sh_dp;
        r_blanks    <= w_sh_blank;
        r_frame_err <= w_err_acc;
      end
    end
  end

  assign bus.digits      = r_digits;
  assign bus.dps         = r_dps;
  assign bus.blanks      = r_blanks;
  assign bus.frame_valid = r_frame_valid;
  assign bus.frame_err   = r_frame_err;

endmodule

// File: tb/tb_display_scan_decoder.sv
// Directed bench for display_scan_decoder with hand-computed frames.
module tb_display_scan_decoder;

  logic clock;
  logic reset;
  int   n_tests;
  int   n_fail;
  int   fv_cnt;
  logic [7:0] pat [10];

  display_scan_decoder_if bus();

  display_scan_decoder #(.STABLE_CYCLES(4)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) begin
    #1;
    if (bus.frame_valid === 1'b1) fv_cnt++;
  end

  task automatic drive(input logic [7:0] a, input logic [7:0] d, input int n);
    bus.an      = a;
    bus.dec_ddp = d;
    repeat (n) @(negedge clock);
  endtask

  task automatic scan_slot(input int i, input logic [7:0] d);
    logic [7:0] a;
    a = 8'h01 << i;
    drive(~a, d, 8);
  endtask

  task automatic check_frame(input string name, input int fv_exp, input int fv_got,
                             input logic [31:0] dig, input logic [7:0] dp,
                             input logic [7:0] bl, input logic err);
    n_tests++;
    if (fv_got !== fv_exp) begin
      n_fail++;
      $display("FAIL %s frame_count got %0d exp %0d", name, fv_got, fv_exp);
    end
    n_tests++;
    if (bus.digits !== dig) begin
      n_fail++;
      $display("FAIL %s digits got %h exp %h", name, bus.digits, dig);
    end
    n_tests++;
    if (bus.dps !== dp || bus.blanks !== bl) begin
      n_fail++;
      $display("FAIL %s dps/blanks got %h/%h exp %h/%h", name, bus.dps, bus.blanks, dp, bl);
    end
    n_tests++;
    if (bus.frame_err !== err) begin
      n_fail++;
      $display("FAIL %s frame_err got %b exp %b", name, bus.frame_err, err);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    drive(8'hFF, 8'hFF, 3);
    reset = 1'b1;
    drive(8'hFF, 8'hFF, 2);
    check_frame("reset_init", 0, fv_cnt, 32'h0, 8'h00, 8'h00, 1'b0);
    n_tests++;
    if (bus.frame_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_init frame_valid got %b exp 0", bus.frame_valid);
    end
  endtask

  task automatic test_full_scan();
    int f0;
    f0 = fv_cnt;
    for (int i = 0; i < 8; i++) scan_slot(i, pat[i]);
    check_frame("full_scan", 1, fv_cnt - f0, 32'h76543210, 8'h00, 8'h00, 1'b0);
  endtask

  task automatic test_reset_mid();
    int f0;
    drive(8'hFF, 8'hFF, 2);
    for (int i = 0; i < 4; i++) scan_slot(i, pat[9]);
    f0 = fv_cnt;
    #2 reset = 1'b0;
    #2;
    check_frame("reset_async", 0, 0, 32'h0, 8'h00, 8'h00, 1'b0);
    drive(8'hFF, 8'hFF, 3);
    reset = 1'b1;
    drive(8'hFF, 8'hFF, 2);
    for (int i = 4; i < 8; i++) scan_slot(i, pat[i]);
    check_frame("reset_partial_discard", 0, fv_cnt - f0, 32'h0, 8'h00, 8'h00, 1'b0);
    f0 = fv_cnt;
    for (int i = 0; i < 4; i++) scan_slot(i, pat[i]);
    check_frame("reset_refill", 1, fv_cnt - f0, 32'h76543210, 8'h00, 8'h00, 1'b0);
  endtask

  task automatic test_stability();
    int f0;
    drive(8'hFF, 8'hFF, 2);
    f0 = fv_cnt;
    for (int i = 0; i < 8; i++) if (i != 3) scan_slot(i, pat[i]);
    drive(8'hF7, 8'h01, 3);
    drive(8'hFF, 8'hFF, 4);
    n_tests++;
    if (fv_cnt - f0 !== 0) begin
      n_fail++;
      $display("FAIL stab_short_glitch frame_count got %0d exp 0", fv_cnt - f0);
    end
    drive(8'hF7, 8'h01, 3);
    n_tests++;
    if (bus.frame_valid !== 1'b0 || fv_cnt - f0 !== 0) begin
      n_fail++;
      $display("FAIL stab_3rd_sample frame_valid got %b exp 0", bus.frame_valid);
    end
    drive(8'hF7, 8'h01, 1);
    n_tests++;
    if (bus.frame_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL stab_4th_sample frame_valid got %b exp 1", bus.frame_valid);
    end
    drive(8'hF7, 8'h01, 1);
    n_tests++;
    if (bus.frame_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL stab_pulse_width frame_valid got %b exp 0", bus.frame_valid);
    end
    drive(8'hF7, 8'h01, 48);
    check_frame("stab_hold50", 1, fv_cnt - f0, 32'h76548210, 8'h00, 8'h00, 1'b0);
  endtask

  task automatic test_blank_dp();
    int f0;
    drive(8'hFF, 8'hFF, 2);
    f0 = fv_cnt;
    for (int i = 0; i < 8; i++) begin
      if (i == 5)      scan_slot(i, 8'hFF);
      else if (i == 2) scan_slot(i, 8'h00);
      else             scan_slot(i, pat[i]);
    end
    check_frame("blank_dp", 1, fv_cnt - f0, 32'h76043810, 8'h04, 8'h20, 1'b0);
  endtask

  task automatic test_invalid_multihot();
    int f0;
    drive(8'hFF, 8'hFF, 2);
    f0 = fv_cnt;
    for (int i = 0; i < 4; i++) scan_slot(i, pat[i]);
    drive(8'hFC, pat[8], 20);
    for (int i = 4; i < 7; i++) scan_slot(i, pat[i]);
    n_tests++;
    if (fv_cnt - f0 !== 0) begin
      n_fail++;
      $display("FAIL multihot_no_frame frame_count got %0d exp 0", fv_cnt - f0);
    end
    scan_slot(7, 8'hAB);
    check_frame("invalid_slot7", 1, fv_cnt - f0, 32'h06543210, 8'h00, 8'h00, 1'b1);
  endtask

  task automatic test_back_to_back();
    int f0;
    f0 = fv_cnt;
    for (int i = 0; i < 8; i++) scan_slot(i, pat[i]);
    check_frame("clean_after_err", 1, fv_cnt - f0, 32'h76543210, 8'h00, 8'h00, 1'b0);
  endtask

  task automatic test_overwrite();
    int f0;
    drive(8'hFF, 8'hFF, 2);
    f0 = fv_cnt;
    scan_slot(0, pat[3]);
    for (int i = 1; i < 7; i++) scan_slot(i, pat[i]);
    scan_slot(0, pat[9]);
    n_tests++;
    if (fv_cnt - f0 !== 0) begin
      n_fail++;
      $display("FAIL overwrite_early frame_count got %0d exp 0", fv_cnt - f0);
    end
    scan_slot(7, pat[7]);
    check_frame("overwrite", 1, fv_cnt - f0, 32'h76543219, 8'h00, 8'h00, 1'b0);
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    fv_cnt  = 0;
    pat[0] = 8'h03; pat[1] = 8'h9F; pat[2] = 8'h25; pat[3] = 8'h0D; pat[4] = 8'h99;
    pat[5] = 8'h49; pat[6] = 8'h41; pat[7] = 8'h1F; pat[8] = 8'h01; pat[9] = 8'h09;
    reset       = 1'b0;
    bus.an      = 8'hFF;
    bus.dec_ddp = 8'hFF;
    @(negedge clock);
    test_reset();
    test_full_scan();
    test_reset_mid();
    test_stability();
    test_blank_dp();
    test_invalid_multihot();
    test_back_to_back();
    test_overwrite();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/display_scan_decoder.md
# display_scan_decoder

Receives the time-multiplexed 8-digit seven-segment drive (`an`, `dec_ddp`) that the chess-clock display path emits and reconstructs the displayed digits as parallel data. It samples the scanned anode/segment lines, captures each digit only after the lines have been stable, and publishes a complete 8-digit frame once every slot has been seen. It is used as an on-chip display monitor and as the checker-side companion of the timer in benches.

## Interface
- `STABLE_CYCLES`, default 4: number of consecutive identical registered samples required before a digit is captured (≥2).
- `clock`  in  1  system clock; the only clock.
- `reset`  in  1  asynchronous, active-low reset.
- `an`  in  8  anode select, active-low; `an[i]=0` selects digit slot i.
- `dec_ddp`  in  8  segments, active-low; bit7=a, bit6=b, … bit1=g, bit0=dp.
- `digits`  out  32  decoded hex values; slot i at `digits[4i+3:4i]`.
- `dps`  out  8  decimal point on, per slot (active-high).
- `blanks`  out  8  slot was blank (all segments a–g off).
- `frame_valid`  out  1  one-cycle pulse: `digits/dps/blanks/frame_err` just updated.
- `frame_err`  out  1  published frame contained at least one unrecognised pattern.

## Operation
- Input stage: `an` and `dec_ddp` registered once into sample `s`, each cycle. Both are on `clock`; no synchroniser.
- Stability counter `cnt`: cleared when `s` differs from the previous `s`, otherwise increments, saturating at `STABLE_CYCLES-1`.
- `armed` flag: set whenever `s` changes; cleared on capture. At most one capture per anode activation.
- Capture condition: `armed` and `cnt==STABLE_CYCLES-1` and `s.an` has exactly one zero bit. `an==8'hFF` (idle) and multi-hot `an` never capture; they only change `s` and rearm.
- Decode of `s.dec_ddp[7:1]` (active-low a..g) to nibble, standard patterns: 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100, 5=0100100, 6=0100000, 7=0001111, 8=0000000, 9=0000100, A=0001000, b=1100000, C=0110001, d=1000010, E=0110000, F=0111000. 1111111 = blank (nibble 0, blank bit 1). Any other pattern = invalid (nibble 0, blank 0, error bit set for the frame).
- `dp` = `~s.dec_ddp[0]`, stored per slot regardless of segment validity.
- Capture writes the slot's nibble/dp/blank into a shadow buffer and sets `seen[i]`. Re-capturing an already-seen slot overwrites it (latest value wins).
- Frame state: COLLECT (`seen!=8'hFF`) → PUBLISH when the capture that sets the last `seen` bit occurs → COLLECT next cycle. PUBLISH copies shadow → outputs, drives `frame_err` from the accumulated error bit, pulses `frame_valid`, clears `seen` and the error accumulator.
- Outputs hold between frames.

## Timing
- Reset (async assert, sync to `clock` on release): `digits=0`, `dps=0`, `blanks=0`, `frame_valid=0`, `frame_err=0`; `s.an=8'hFF`, `s.dec_ddp=8'hFF`, `cnt=0`, `armed=1`, `seen=0`; shadow cleared. Partial frame in progress is discarded.
- A new input value presented before edge k appears in `s` at edge k; if held, capture happens at edge k+STABLE_CYCLES-1.
- Outputs update and `frame_valid` is high for exactly the one cycle after the completing capture edge.
- A capture in the same cycle as PUBLISH (impossible for a new slot with STABLE_CYCLES≥2) is not required to be handled; a glitch shorter than STABLE_CYCLES samples never captures.
- Scan order is irrelevant; slots may arrive in any order.

## Test plan
- Reset: assert `reset=0` mid-scan → all outputs 0, `frame_valid` stays 0; release and scan → first frame only after all 8 slots seen again.
- Full scan, slot i shows digit i (`an=~(1<<i)`, `dec_ddp` = pattern of i with dp off, e.g. slot0 0x03, slot1 0x9F), 8 cycles each → one `frame_valid`, `digits=32'h76543210`, `dps=0`, `blanks=0`, `frame_err=0`.
- Stability filter, STABLE_CYCLES=4: hold slot3 for 3 cycles with 0x01 then change → no capture; hold 4 cycles → captured exactly at 4th sample edge, once even if held 50 cycles.
- Blank and dp: slot5 `dec_ddp=8'hFF`, slot2 `8'h00` → `blanks[5]=1`, `digits[23:20]=0`, `dps[2]=1`, `digits[11:8]=8`.
- Invalid/multi-hot: slot7 `dec_ddp=8'hAB` → frame published with `frame_err=1`, `digits[31:28]=0`; `an=8'hFC` for 20 cycles → no capture, `seen` unchanged; next clean frame → `frame_err=0`.
- Overwrite: slot0 captured as 3, rescanned as 9 before frame completes → published `digits[3:0]=9`.
